pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/pipe_ctrl_if.sv | 19 +
 rtl/pipe_stall_enc.sv | 20 ++
 rtl/pipe_ctrl.sv | 109 ++++++++++
 tb/tb_pipe_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: stall bus geometry,
// per-stage stall bit positions and the redirect FSM state encoding.
package pipe_ctrl_pkg;

    localparam int STALL_W   = 6;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    typedef logic [STALL_W-1:0] stall_bus_t;

    // IDLE: no redirect outstanding. PEND: a taken branch was seen while the
    // PC was frozen; its target waits in a latch until the PC can move.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } pipe_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall request bundle: four per-stage stall requests going in, the
// resolved stage stall vector coming back.
// The master raises requests and reads the vector; the slave (the
// priority encoder) reads requests and drives the vector. There is no
// handshake: the vector is a pure combinational function of the requests.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic       req_if;
    logic       req_id;
    logic       req_ex;
    logic       req_mem;
    stall_bus_t stall;

    modport master (output req_if, output req_id, output req_ex, output req_mem,
                    input stall);
    modport slave  (input req_if, input req_id, input req_ex, input req_mem,
                    output stall);
endinterface

// File: rtl/pipe_stall_enc.sv
// Stall priority encoder: a stall raised by a later stage also freezes every
// earlier stage, so the deepest requesting stage decides the vector.
module pipe_stall_enc
    import pipe_ctrl_pkg::*;
(
    pipe_ctrl_if.slave bus
);

    // Each stage is frozen when it or any later stage asks for a stall; WB never stalls.
    always_comb begin
        bus.stall            = '0;
        bus.stall[STALL_PC]  = bus.req_if | bus.req_id | bus.req_ex | bus.req_mem;
        bus.stall[STALL_IF]  = bus.req_if | bus.req_id | bus.req_ex | bus.req_mem;
        bus.stall[STALL_ID]  = bus.req_id | bus.req_ex | bus.req_mem;
        bus.stall[STALL_EX]  = bus.req_ex | bus.req_mem;
        bus.stall[STALL_MEM] = bus.req_mem;
        bus.stall[STALL_WB]  = 1'b0;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stage stall vector, branch flush/redirect sequencing and
// performance counters. A taken branch that arrives while the PC is frozen is
// parked in PEND and replayed as a single PC load on the first unfrozen cycle.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_if_i,
    input  logic        req_id_i,
    input  logic        req_ex_i,
    input  logic        req_mem_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic        redir_valid_o,
    output logic [31:0] redir_pc_o,
    output logic        pend_o,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_flush_o
);

    pipe_ctrl_if u_stall_if ();

    assign u_stall_if.req_if  = req_if_i;
    assign u_stall_if.req_id  = req_id_i;
    assign u_stall_if.req_ex  = req_ex_i;
    assign u_stall_if.req_mem = req_mem_i;

    pipe_stall_enc u_enc (
        .bus (u_stall_if.slave)
    );

    pipe_state_t state_q, state_d;
    logic [31:0] tgt_q;
    logic        tgt_load;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;
    logic        pc_stall;

    // Outputs are held quiet while reset is asserted, so the vector is gated here.
    always_comb begin
        stall_o = rst ? '0 : u_stall_if.stall;
    end

    assign pc_stall     = stall_o[STALL_PC];
    assign perf_stall_o = perf_stall_q;
    assign perf_flush_o = perf_flush_q;

    // Next state and redirect/flush outputs; a redirect fires in the same cycle the PC is free.
    always_comb begin
        state_d       = state_q;
        flush_o       = 1'b0;
        redir_valid_o = 1'b0;
        redir_pc_o    = 32'h0;
        pend_o        = 1'b0;
        tgt_load      = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (br_taken_i) begin
                        flush_o = 1'b1;
                        if (!pc_stall) begin
                            redir_valid_o = 1'b1;
                            redir_pc_o    = br_target_i;
                        end else begin
                            tgt_load = 1'b1;
                            state_d  = ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    // EX holds a squashed bubble here, so br_taken_i is not looked at.
                    flush_o = 1'b1;
                    pend_o  = 1'b1;
                    if (!pc_stall) begin
                        redir_valid_o = 1'b1;
                        redir_pc_o    = tgt_q;
                        state_d       = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, parked target and counters; reset wins over everything on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tgt_q        <= 32'h0;
            perf_stall_q <= 32'h0;
            perf_flush_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (tgt_load) begin
                tgt_q <= br_target_i;
            end
            if (pc_stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (redir_valid_o) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed branch/stall/reset scenarios followed by
// random traffic, checked against a behavioural model through a scoreboard.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int OBS_W = 6 + 1 + 1 + 32 + 1 + 32 + 32;

    logic        clk;
    logic        rst;
    logic        br_taken;
    logic [31:0] br_target;
    logic        flush_o;
    logic        redir_valid_o;
    logic [31:0] redir_pc_o;
    logic        pend_o;
    logic [31:0] perf_stall_o;
    logic [31:0] perf_flush_o;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_if_i      (bus.req_if),
        .req_id_i      (bus.req_id),
        .req_ex_i      (bus.req_ex),
        .req_mem_i     (bus.req_mem),
        .br_taken_i    (br_taken),
        .br_target_i   (br_target),
        .stall_o       (bus.stall),
        .flush_o       (flush_o),
        .redir_valid_o (redir_valid_o),
        .redir_pc_o    (redir_pc_o),
        .pend_o        (pend_o),
        .perf_stall_o  (perf_stall_o),
        .perf_flush_o  (perf_flush_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst         = 1'b1;
        bus.req_if  = 1'b0;
        bus.req_id  = 1'b0;
        bus.req_ex  = 1'b0;
        bus.req_mem = 1'b0;
        br_taken    = 1'b0;
        br_target   = 32'h0;
    end

    // ---------------- scoreboard state ----------------
    logic [OBS_W-1:0] exp_q[$];
    logic [31:0]      redir_q[$];
    int               n_vec = 0;
    int               n_err = 0;

    // Reference model: one outstanding redirect slot plus two counters.
    logic        m_pending = 1'b0;
    logic [31:0] m_tgt     = 32'h0;
    logic [31:0] m_ps      = 32'h0;
    logic [31:0] m_pf      = 32'h0;

    // ---------------- driver tasks ----------------
    // req = {mem, ex, id, if}. Drives one cycle's inputs and queues what the
    // outputs must look like during that cycle.
    task automatic apply(input logic r, input logic [3:0] req,
                         input logic br, input logic [31:0] tgt);
        int          depth;
        logic [5:0]  es;
        logic        ef, erv, epend, pc_stall;
        logic [31:0] epc;
        rst         = r;
        bus.req_if  = req[0];
        bus.req_id  = req[1];
        bus.req_ex  = req[2];
        bus.req_mem = req[3];
        br_taken    = br;
        br_target   = tgt;

        es = '0; ef = 1'b0; erv = 1'b0; epend = 1'b0; epc = 32'h0;
        if (r) begin
            exp_q.push_back({es, ef, erv, epc, epend, m_ps, m_pf});
            m_pending = 1'b0;
            m_tgt     = 32'h0;
            m_ps      = 32'h0;
            m_pf      = 32'h0;
        end else begin
            // Number of frozen stages counted from PC: deepest requester decides.
            depth = req[3] ? 5 : req[2] ? 4 : req[1] ? 3 : req[0] ? 2 : 0;
            es       = 6'((1 << depth) - 1);
            pc_stall = (depth != 0);
            if (m_pending) begin
                ef    = 1'b1;
                epend = 1'b1;
                if (!pc_stall) begin
                    erv = 1'b1;
                    epc = m_tgt;
                end
            end else if (br) begin
                ef = 1'b1;
                if (!pc_stall) begin
                    erv = 1'b1;
                    epc = tgt;
                end
            end
            exp_q.push_back({es, ef, erv, epc, epend, m_ps, m_pf});
            if (erv) redir_q.push_back(epc);
            if (m_pending && !pc_stall) begin
                m_pending = 1'b0;
            end else if (!m_pending && br && pc_stall) begin
                m_pending = 1'b1;
                m_tgt     = tgt;
            end
            m_ps = m_ps + 32'(pc_stall);
            m_pf = m_pf + 32'(erv);
        end
    endtask

    task automatic cycle(input logic r, input logic [3:0] req,
                         input logic br, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        apply(r, req, br, tgt);
    endtask

    // Preload the stall counter to its top value, then run one stalled cycle.
    task automatic preload_stall_cnt(input logic [3:0] req);
        @(posedge clk);
        #1;
        force dut.perf_stall_q = 32'hFFFF_FFFF;
        #1;
        release dut.perf_stall_q;
        m_ps = 32'hFFFF_FFFF;
        apply(1'b0, req, 1'b0, 32'h0);
    endtask

    // ---------------- monitor ----------------
    // Compare the full output picture once per cycle, away from the active edge,
    // and separately match every redirect pulse against the expected targets.
    always @(negedge clk) begin
        logic [OBS_W-1:0] e, a;
        logic [31:0]      t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.stall, flush_o, redir_valid_o, redir_pc_o, pend_o,
                 perf_stall_o, perf_flush_o};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL outputs t=%0t stall/flush/rv/pc/pend/ps/pf act=%b/%b/%b/%h/%b/%h/%h exp=%b/%b/%b/%h/%b/%h/%h",
                         $time, a[104:99], a[98], a[97], a[96:65], a[64], a[63:32], a[31:0],
                         e[104:99], e[98], e[97], e[96:65], e[64], e[63:32], e[31:0]);
            end
        end
        if (redir_valid_o === 1'b1) begin
            n_vec++;
            if (redir_q.size() == 0) begin
                n_err++;
                $display("FAIL redirect_spurious t=%0t act_pc=%h exp=no_pulse", $time, redir_pc_o);
            end else begin
                t = redir_q.pop_front();
                if (redir_pc_o !== t) begin
                    n_err++;
                    $display("FAIL redirect_target t=%0t act=%h exp=%h", $time, redir_pc_o, t);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  rreq;
        logic        rbr, rrst;
        logic [31:0] rtgt;

        // Reset held for two cycles.
        cycle(1'b1, 4'b0000, 1'b0, 32'h0);
        cycle(1'b1, 4'b0000, 1'b0, 32'h0);

        // Stall priority.
        cycle(1'b0, 4'b0010, 1'b0, 32'h0);
        cycle(1'b0, 4'b1010, 1'b0, 32'h0);
        cycle(1'b0, 4'b0100, 1'b0, 32'h0);
        cycle(1'b0, 4'b0001, 1'b0, 32'h0);
        cycle(1'b0, 4'b0000, 1'b0, 32'h0);

        // Clean reset so the flush counter starts from zero.
        cycle(1'b1, 4'b0000, 1'b0, 32'h0);

        // Unstalled branch redirects in the same cycle; counter 0 -> 1.
        cycle(1'b0, 4'b0000, 1'b1, 32'h0000_0100);
        cycle(1'b0, 4'b0000, 1'b0, 32'h0);

        // Branch under a 3-cycle memory stall, with a second branch ignored in PEND.
        cycle(1'b0, 4'b1000, 1'b1, 32'h0000_0200);
        cycle(1'b0, 4'b1000, 1'b1, 32'h0000_0300);
        cycle(1'b0, 4'b1000, 1'b0, 32'h0);
        cycle(1'b0, 4'b0000, 1'b0, 32'h0);
        cycle(1'b0, 4'b0000, 1'b0, 32'h0);

        // Reset while pending: the parked redirect is dropped.
        cycle(1'b0, 4'b0100, 1'b1, 32'h0000_0400);
        cycle(1'b0, 4'b0100, 1'b0, 32'h0);
        cycle(1'b1, 4'b0100, 1'b1, 32'h0000_0500);
        cycle(1'b0, 4'b0000, 1'b0, 32'h0);
        cycle(1'b0, 4'b0000, 1'b0, 32'h0);

        // Stall counter wrap.
        preload_stall_cnt(4'b0001);
        cycle(1'b0, 4'b0000, 1'b0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rreq[0] = ($urandom_range(0, 99) < 20);
            rreq[1] = ($urandom_range(0, 99) < 20);
            rreq[2] = ($urandom_range(0, 99) < 15);
            rreq[3] = ($urandom_range(0, 99) < 15);
            rbr     = ($urandom_range(0, 99) < 30);
            rrst    = ($urandom_range(0, 99) < 2);
            rtgt    = {$urandom_range(0, 65535), 14'h0, 2'b00};
            rtgt    = rtgt | 32'($urandom_range(0, 16383) << 2);
            cycle(rrst, rreq, rbr, rtgt);
        end

        // Drain, then confirm nothing expected was left unmatched.
        cycle(1'b0, 4'b0000, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0 || redir_q.size() != 0) begin
            n_err++;
            $display("FAIL drain act_exp_left=%0d act_redir_left=%0d exp=0/0",
                     exp_q.size(), redir_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
